// File: rtl/vx_mem_wb_queue.sv
// Two-entry decoupling queue between the memory and writeback stages.
// Writeback data is selected at enqueue so the writeback stage sees one data bus.
module vx_mem_wb_queue #(
  parameter int NT  = 4,
  parameter int NWB = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_push,
  input  logic [NT-1:0]       in_valid,
  input  logic [NT*32-1:0]    in_alu_result,
  input  logic [NT*32-1:0]    in_mem_result,
  input  logic [31:0]         in_PC_next,
  input  logic [4:0]          in_rd,
  input  logic [1:0]          in_wb,
  input  logic [NWB-1:0]      in_warp_num,
  input  logic                in_flush,
  input  logic                in_wb_ready,
  output logic                out_stall,
  output logic                out_wb_valid,
  output logic [NT-1:0]       out_valid,
  output logic [4:0]          out_rd,
  output logic [1:0]          out_wb,
  output logic [NT*32-1:0]    out_write_data,
  output logic [NWB-1:0]      out_warp_num,
  output logic                out_overflow,
  output logic [31:0]         out_retired
);

  localparam int DW = NT * 32;

  logic [NT-1:0]  r_valid [2];
  logic [DW-1:0]  r_data  [2];
  logic [4:0]     r_rd    [2];
  logic [1:0]     r_wb    [2];
  logic [NWB-1:0] r_warp  [2];
  logic           r_wptr;
  logic           r_rptr;
  logic [1:0]     r_count;
  logic           r_overflow;
  logic [31:0]    r_retired;

  logic           w_any_lane;
  logic           w_push_ok;
  logic           w_push_ovf;
  logic           w_pop;
  logic           w_nonempty;
  logic [DW-1:0]  w_sel_data;

  assign w_any_lane = |in_valid;
  assign w_nonempty = (r_count != 2'd0);
  assign out_stall  = (r_count == 2'd2);
  assign w_push_ok  = in_push & w_any_lane & ~out_stall & ~in_flush;
  assign w_push_ovf = in_push & w_any_lane & out_stall;
  assign w_pop      = w_nonempty & in_wb_ready & ~in_flush;

  always_comb begin
    w_sel_data = '0;
    case (in_wb)
      2'd1:    w_sel_data = in_alu_result;
      2'd2:    w_sel_data = in_mem_result;
      2'd3:    w_sel_data = {NT{in_PC_next}};
      default: w_sel_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_valid[i] <= '0;
        r_data[i]  <= '0;
        r_rd[i]    <= '0;
        r_wb[i]    <= '0;
        r_warp[i]  <= '0;
      end
    end else if (w_push_ok) begin
      r_valid[r_wptr] <= in_valid;
      r_data[r_wptr]  <= w_sel_data;
      r_rd[r_wptr]    <= in_rd;
      r_wb[r_wptr]    <= in_wb;
      r_warp[r_wptr]  <= in_warp_num;
    end
  end

  // Flush wins over any push or pop presented in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
      r_retired  <= '0;
    end else begin
      if (w_push_ovf) r_overflow <= 1'b1;
      if (in_flush) begin
        r_wptr  <= 1'b0;
        r_rptr  <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_push_ok) r_wptr <= ~r_wptr;
        if (w_pop) begin
          r_rptr    <= ~r_rptr;
          r_retired <= r_retired + 32'd1;
        end
        case ({w_push_ok, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign out_wb_valid   = w_nonempty;
  assign out_valid      = w_nonempty ? r_valid[r_rptr] : '0;
  assign out_rd         = w_nonempty ? r_rd[r_rptr]    : '0;
  assign out_wb         = w_nonempty ? r_wb[r_rptr]    : '0;
  assign out_write_data = w_nonempty ? r_data[r_rptr]  : '0;
  assign out_warp_num   = w_nonempty ? r_warp[r_rptr]  : '0;
  assign out_overflow   = r_overflow;
  assign out_retired    = r_retired;

endmodule

// File: tb/tb_vx_mem_wb_queue.sv
// Bench for vx_mem_wb_queue: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_vx_mem_wb_queue;
  localparam int NT  = 4;
  localparam int NWB = 3;
  localparam int DW  = NT * 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_push;
  logic [NT-1:0]  in_valid;
  logic [DW-1:0]  in_alu_result;
  logic [DW-1:0]  in_mem_result;
  logic [31:0]    in_PC_next;
  logic [4:0]     in_rd;
  logic [1:0]     in_wb;
  logic [NWB-1:0] in_warp_num;
  logic           in_flush;
  logic           in_wb_ready;
  logic           out_stall;
  logic           out_wb_valid;
  logic [NT-1:0]  out_valid;
  logic [4:0]     out_rd;
  logic [1:0]     out_wb;
  logic [DW-1:0]  out_write_data;
  logic [NWB-1:0] out_warp_num;
  logic           out_overflow;
  logic [31:0]    out_retired;

  vx_mem_wb_queue #(.NT(NT), .NWB(NWB)) dut (
    .clk(clk), .reset(reset),
    .in_push(in_push), .in_valid(in_valid),
    .in_alu_result(in_alu_result), .in_mem_result(in_mem_result),
    .in_PC_next(in_PC_next), .in_rd(in_rd), .in_wb(in_wb),
    .in_warp_num(in_warp_num), .in_flush(in_flush), .in_wb_ready(in_wb_ready),
    .out_stall(out_stall), .out_wb_valid(out_wb_valid), .out_valid(out_valid),
    .out_rd(out_rd), .out_wb(out_wb), .out_write_data(out_write_data),
    .out_warp_num(out_warp_num), .out_overflow(out_overflow),
    .out_retired(out_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NT-1:0]  v;
    logic [DW-1:0]  d;
    logic [4:0]     rd;
    logic [1:0]     wb;
    logic [NWB-1:0] w;
  } ent_t;

  ent_t        mq[$];
  bit          m_ovf;
  int unsigned m_ret;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Writeback data as the writeback stage should see it, lane by lane.
  function automatic logic [DW-1:0] expect_data(input logic [1:0] wb, input logic [DW-1:0] alu,
                                                input logic [DW-1:0] mem, input logic [31:0] pc);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NT; i++) begin
      if (wb == 2'd1)      r[32*i +: 32] = alu[32*i +: 32];
      else if (wb == 2'd2) r[32*i +: 32] = mem[32*i +: 32];
      else if (wb == 2'd3) r[32*i +: 32] = pc;
      else                 r[32*i +: 32] = 32'd0;
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    ent_t h;
    bit   ne;
    ne = (mq.size() != 0);
    h.v = '0; h.d = '0; h.rd = '0; h.wb = '0; h.w = '0;
    if (ne) h = mq[0];
    chk({tag, ".stall"},    DW'(out_stall),    DW'(mq.size() == 2));
    chk({tag, ".wb_valid"}, DW'(out_wb_valid), DW'(ne));
    chk({tag, ".valid"},    DW'(out_valid),    DW'(h.v));
    chk({tag, ".rd"},       DW'(out_rd),       DW'(h.rd));
    chk({tag, ".wb"},       DW'(out_wb),       DW'(h.wb));
    chk({tag, ".data"},     out_write_data,    h.d);
    chk({tag, ".warp"},     DW'(out_warp_num), DW'(h.w));
    chk({tag, ".overflow"}, DW'(out_overflow), DW'(m_ovf));
    chk({tag, ".retired"},  DW'(out_retired),  DW'(m_ret));
  endtask

  // Advance one clock with the inputs currently driven, update the model, check.
  task automatic cycle(input string tag);
    bit   full, val, accept, pop, flush;
    ent_t e;
    full   = (mq.size() == 2);
    val    = in_push && (in_valid != '0);
    flush  = in_flush;
    accept = val && !full && !flush;
    pop    = (mq.size() > 0) && in_wb_ready && !flush;
    if (val && full) m_ovf = 1'b1;
    e.v  = in_valid;
    e.d  = expect_data(in_wb, in_alu_result, in_mem_result, in_PC_next);
    e.rd = in_rd;
    e.wb = in_wb;
    e.w  = in_warp_num;
    @(posedge clk);
    #1;
    if (flush) mq.delete();
    else begin
      if (pop) begin
        void'(mq.pop_front());
        m_ret++;
      end
      if (accept) mq.push_back(e);
    end
    check_all(tag);
  endtask

  task automatic drive(input logic push, input logic [NT-1:0] mask, input logic [1:0] wb,
                       input logic [4:0] rd, input logic [NWB-1:0] warp,
                       input logic ready, input logic flush);
    in_push = push; in_valid = mask; in_wb = wb; in_rd = rd;
    in_warp_num = warp; in_wb_ready = ready; in_flush = flush;
  endtask

  initial begin
    int unsigned ret_save;
    reset = 1'b1;
    drive(0, '0, 0, 0, 0, 0, 0);
    in_alu_result = '0; in_mem_result = '0; in_PC_next = '0;
    m_ovf = 0; m_ret = 0;
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // single push, ALU select
    in_alu_result = {32'd4, 32'd3, 32'd2, 32'd1};
    drive(1, 4'b1111, 2'd1, 5'd5, 3'd2, 1, 0);
    cycle("single.push");
    chk("single.data_const", out_write_data, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("single.rd_const", DW'(out_rd), DW'(5'd5));
    drive(0, '0, 0, 0, 0, 1, 0);
    cycle("single.pop");
    chk("single.retired_const", DW'(out_retired), DW'(32'd1));

    // data select: MEM, PC_next, none, back to back with ready high
    in_mem_result = {NT{32'hAA}};
    in_PC_next    = 32'h80000010;
    drive(1, 4'b1010, 2'd2, 5'd7, 3'd1, 1, 0);
    cycle("sel.mem");
    chk("sel.mem_const", out_write_data, {NT{32'hAA}});
    drive(1, 4'b0110, 2'd3, 5'd8, 3'd3, 1, 0);
    cycle("sel.pc");
    chk("sel.pc_const", out_write_data, {NT{32'h80000010}});
    drive(1, 4'b0001, 2'd0, 5'd9, 3'd4, 1, 0);
    cycle("sel.none");
    chk("sel.none_const", out_write_data, '0);
    drive(0, '0, 0, 0, 0, 1, 0);
    cycle("sel.drain");
    chk("sel.retired_const", DW'(out_retired), DW'(32'd4));

    // back-pressure and overflow
    drive(1, 4'b1111, 2'd1, 5'd1, 3'd1, 0, 0);
    in_alu_result = {32'h11, 32'h12, 32'h13, 32'h14};
    cycle("full.p1");
    in_alu_result = {32'h21, 32'h22, 32'h23, 32'h24};
    drive(1, 4'b1111, 2'd1, 5'd2, 3'd2, 0, 0);
    cycle("full.p2");
    chk("full.stall_const", DW'(out_stall), DW'(1'b1));
    drive(1, 4'b1111, 2'd1, 5'd3, 3'd3, 0, 0);
    cycle("full.p3");
    chk("full.overflow_const", DW'(out_overflow), DW'(1'b1));
    drive(0, '0, 0, 0, 0, 1, 0);
    cycle("full.pop1");
    chk("full.head2_rd_const", DW'(out_rd), DW'(5'd2));
    cycle("full.pop2");
    chk("full.empty_const", DW'(out_wb_valid), DW'(1'b0));

    // bubble
    ret_save = m_ret;
    drive(1, 4'b0000, 2'd1, 5'd6, 3'd1, 1, 0);
    cycle("bubble");
    chk("bubble.retired_const", DW'(out_retired), DW'(ret_save));

    // flush with two queued, push and ready in same cycle
    drive(1, 4'b0011, 2'd1, 5'd10, 3'd5, 0, 0);
    cycle("flush.p1");
    cycle("flush.p2");
    ret_save = m_ret;
    drive(1, 4'b0011, 2'd1, 5'd11, 3'd6, 1, 1);
    cycle("flush.do");
    chk("flush.stall_const", DW'(out_stall), DW'(1'b0));
    chk("flush.retired_const", DW'(out_retired), DW'(ret_save));
    drive(0, '0, 0, 0, 0, 0, 1);
    cycle("flush.empty");

    // reset between edges with two entries queued
    drive(1, 4'b1111, 2'd3, 5'd12, 3'd7, 0, 0);
    cycle("mreset.p1");
    cycle("mreset.p2");
    #3;
    reset = 1'b1;
    #1;
    mq.delete(); m_ovf = 0; m_ret = 0;
    check_all("mreset");
    @(negedge clk);
    reset = 1'b0;
    drive(0, '0, 0, 0, 0, 0, 0);
    cycle("mreset.idle");

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [NT-1:0] m;
      m = ($urandom_range(0, 7) == 0) ? '0 : NT'($urandom);
      for (int i = 0; i < NT; i++) begin
        in_alu_result[32*i +: 32] = $urandom;
        in_mem_result[32*i +: 32] = $urandom;
      end
      in_PC_next = $urandom;
      drive($urandom_range(0, 3) != 0, m, 2'($urandom), 5'($urandom), NWB'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
